mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between the instruction-fetch stage (IF) and the load/store unit (LSU) of the RV64 pipeline.
- Arbitrates between the two requesters and registers the winning request onto the memory port.
- Tracks exactly one outstanding transaction and routes the response back to its owner.
- Sits between the IF/MEM pipeline stages and the memory model; the pipeline stalls on the absence of grant.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_starve_counter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter_pkg
// Brief  : Shared state and owner encodings for the memory port arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_WAIT_GNT  = 2'd1,
        ARB_WAIT_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_LSU = 1'b1
    } mem_owner_e;

    localparam int STARVE_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
// Module : arb_starve_counter
// Brief  : Saturating count of LSU wins while IF waits; flags the limit.
// Rev    : 1.0 - initial release
// ============================================================================
module arb_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    localparam logic [STARVE_CNT_W-1:0] c_LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign limit_hit = (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Shares one memory port between IF and LSU, one transaction in flight.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_be_i,
    output logic                lsu_gnt_o,
    output logic                lsu_rvalid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                protocol_err_o
);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    mem_owner_e          r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_be;
    logic                r_proto_err;

    logic w_arb_en;
    logic w_if_win;
    logic w_if_gnt;
    logic w_lsu_gnt;
    logic w_resp;
    logic w_limit_hit;

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .inc       (w_lsu_gnt && if_req_i),
        .clr       (w_if_gnt),
        .limit_hit (w_limit_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration is open in IDLE and on the response cycle, which lets a
    // waiting requester go back-to-back without an idle bubble.
    always_comb begin
        w_arb_en    = (r_state == ARB_IDLE) ||
                      ((r_state == ARB_WAIT_RESP) && mem_rvalid_i);
        w_if_win    = if_req_i && (!lsu_req_i || w_limit_hit);
        w_if_gnt    = w_arb_en && w_if_win;
        w_lsu_gnt   = w_arb_en && lsu_req_i && !w_if_win;
        w_resp      = (r_state == ARB_WAIT_RESP) && mem_rvalid_i;
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_if_gnt || w_lsu_gnt) w_state_nxt = ARB_WAIT_GNT;
            end
            ARB_WAIT_GNT: begin
                if (mem_gnt_i) w_state_nxt = ARB_WAIT_RESP;
            end
            ARB_WAIT_RESP: begin
                if (mem_rvalid_i)
                    w_state_nxt = (w_if_gnt || w_lsu_gnt) ? ARB_WAIT_GNT : ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= OWNER_IF;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_if_gnt) begin
                r_owner <= OWNER_IF;
                r_we    <= 1'b0;
                r_addr  <= if_addr_i;
                r_wdata <= '0;
                r_be    <= '1;
            end else if (w_lsu_gnt) begin
                r_owner <= OWNER_LSU;
                r_we    <= lsu_we_i;
                r_addr  <= lsu_addr_i;
                r_wdata <= lsu_wdata_i;
                r_be    <= lsu_be_i;
            end
            // A response with nothing outstanding is dropped and latched as an error.
            if (mem_rvalid_i && (r_state != ARB_WAIT_RESP))
                r_proto_err <= 1'b1;
        end
    end

    assign if_gnt_o       = w_if_gnt;
    assign lsu_gnt_o      = w_lsu_gnt;
    assign if_rvalid_o    = w_resp && (r_owner == OWNER_IF);
    assign lsu_rvalid_o   = w_resp && (r_owner == OWNER_LSU);
    assign if_rdata_o     = if_rvalid_o  ? mem_rdata_i : '0;
    assign lsu_rdata_o    = lsu_rvalid_o ? mem_rdata_i : '0;
    assign mem_req_o      = (r_state == ARB_WAIT_GNT);
    assign mem_we_o       = r_we;
    assign mem_addr_o     = r_addr;
    assign mem_wdata_o    = r_wdata;
    assign mem_be_o       = r_be;
    assign protocol_err_o = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Directed bench with a transaction-level reference model of the arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_AW    = 64;
    localparam int c_DW    = 64;
    localparam int c_LIMIT = 4;

    logic            clk;
    logic            rst;
    logic            if_req_i;
    logic [c_AW-1:0] if_addr_i;
    logic            if_gnt_o;
    logic            if_rvalid_o;
    logic [c_DW-1:0] if_rdata_o;
    logic            lsu_req_i;
    logic            lsu_we_i;
    logic [c_AW-1:0] lsu_addr_i;
    logic [c_DW-1:0] lsu_wdata_i;
    logic [7:0]      lsu_be_i;
    logic            lsu_gnt_o;
    logic            lsu_rvalid_o;
    logic [c_DW-1:0] lsu_rdata_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [c_AW-1:0] mem_addr_o;
    logic [c_DW-1:0] mem_wdata_o;
    logic [7:0]      mem_be_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [c_DW-1:0] mem_rdata_i;
    logic            protocol_err_o;

    int n_cmp = 0;
    int n_bad = 0;
    int n_lsu_rv = 0;

    mem_port_arbiter #(
        .ADDR_W       (c_AW),
        .DATA_W       (c_DW),
        .STARVE_LIMIT (c_LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_i       (if_req_i),
        .if_addr_i      (if_addr_i),
        .if_gnt_o       (if_gnt_o),
        .if_rvalid_o    (if_rvalid_o),
        .if_rdata_o     (if_rdata_o),
        .lsu_req_i      (lsu_req_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_be_i       (lsu_be_i),
        .lsu_gnt_o      (lsu_gnt_o),
        .lsu_rvalid_o   (lsu_rvalid_o),
        .lsu_rdata_o    (lsu_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_be_o       (mem_be_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .protocol_err_o (protocol_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a request is either on the port, outstanding, or absent.
    bit              m_on_port;
    bit              m_outstanding;
    bit              m_owner_lsu;
    bit              m_err;
    int              m_starve;
    logic            m_we;
    logic [c_AW-1:0] m_addr;
    logic [c_DW-1:0] m_wdata;
    logic [7:0]      m_be;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_if_gnt", 64'(if_gnt_o), 0);
                chk("rst_lsu_gnt", 64'(lsu_gnt_o), 0);
                chk("rst_if_rvalid", 64'(if_rvalid_o), 0);
                chk("rst_lsu_rvalid", 64'(lsu_rvalid_o), 0);
                chk("rst_if_rdata", if_rdata_o, 0);
                chk("rst_lsu_rdata", lsu_rdata_o, 0);
                chk("rst_mem_req", 64'(mem_req_o), 0);
                chk("rst_mem_we", 64'(mem_we_o), 0);
                chk("rst_mem_addr", mem_addr_o, 0);
                chk("rst_mem_wdata", mem_wdata_o, 0);
                chk("rst_mem_be", 64'(mem_be_o), 0);
                chk("rst_err", 64'(protocol_err_o), 0);
                m_on_port = 0; m_outstanding = 0; m_owner_lsu = 0;
                m_err = 0; m_starve = 0;
                m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
            end else begin
                bit arb, ifw, lsuw, resp;
                arb  = !m_on_port && (!m_outstanding || mem_rvalid_i);
                ifw  = arb && if_req_i && (!lsu_req_i || m_starve >= c_LIMIT);
                lsuw = arb && lsu_req_i && !ifw;
                resp = m_outstanding && mem_rvalid_i;
                chk("m_if_gnt", 64'(if_gnt_o), 64'(ifw));
                chk("m_lsu_gnt", 64'(lsu_gnt_o), 64'(lsuw));
                chk("m_if_rvalid", 64'(if_rvalid_o), 64'(resp && !m_owner_lsu));
                chk("m_lsu_rvalid", 64'(lsu_rvalid_o), 64'(resp && m_owner_lsu));
                if (resp && !m_owner_lsu) chk("m_if_rdata", if_rdata_o, mem_rdata_i);
                if (resp && m_owner_lsu)  chk("m_lsu_rdata", lsu_rdata_o, mem_rdata_i);
                chk("m_mem_req", 64'(mem_req_o), 64'(m_on_port));
                if (m_on_port) begin
                    chk("m_mem_we", 64'(mem_we_o), 64'(m_we));
                    chk("m_mem_addr", mem_addr_o, m_addr);
                    chk("m_mem_be", 64'(mem_be_o), 64'(m_be));
                    if (m_owner_lsu) chk("m_mem_wdata", mem_wdata_o, m_wdata);
                end
                chk("m_err", 64'(protocol_err_o), 64'(m_err));
                if (lsu_rvalid_o) n_lsu_rv++;
                // Advance to the state after the coming rising edge.
                if (mem_rvalid_i && !m_outstanding) m_err = 1;
                if (resp) m_outstanding = 0;
                if (m_on_port && mem_gnt_i) begin
                    m_on_port = 0;
                    m_outstanding = 1;
                end
                if (ifw) begin
                    m_on_port = 1; m_owner_lsu = 0; m_starve = 0;
                    m_we = 0; m_addr = if_addr_i; m_be = 8'hFF;
                end else if (lsuw) begin
                    m_on_port = 1; m_owner_lsu = 1;
                    m_we = lsu_we_i; m_addr = lsu_addr_i;
                    m_wdata = lsu_wdata_i; m_be = lsu_be_i;
                    if (if_req_i && m_starve < c_LIMIT) m_starve++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string grants;
        bit    acc;
        int    n_l_before_i;
        int    rv_start;
        rst = 1; if_req_i = 0; if_addr_i = '0;
        lsu_req_i = 0; lsu_we_i = 0; lsu_addr_i = '0; lsu_wdata_i = '0; lsu_be_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
        cyc(); cyc();
        rst = 0;
        cyc();

        // 1: IF only, grant after 2 cycles, response 3 cycles later
        if_req_i = 1; if_addr_i = 64'h100;
        @(negedge clk); chk("t1_if_gnt", 64'(if_gnt_o), 1);
        cyc(); if_req_i = 0;
        @(negedge clk); chk("t1_mem_req", 64'(mem_req_o), 1); chk("t1_mem_addr", mem_addr_o, 64'h100);
        cyc(); mem_gnt_i = 1;
        cyc(); mem_gnt_i = 0;
        cyc(); cyc();
        mem_rvalid_i = 1; mem_rdata_i = 64'hDEAD;
        @(negedge clk);
        chk("t1_if_rvalid", 64'(if_rvalid_o), 1);
        chk("t1_if_rdata", if_rdata_o, 64'hDEAD);
        chk("t1_lsu_rvalid", 64'(lsu_rvalid_o), 0);
        cyc(); mem_rvalid_i = 0; mem_rdata_i = '0;
        cyc();

        // 2: simultaneous requests, LSU store first, IF back-to-back
        lsu_req_i = 1; lsu_we_i = 1; lsu_addr_i = 64'h40; lsu_wdata_i = 64'h1234; lsu_be_i = 8'h0F;
        if_req_i = 1; if_addr_i = 64'h300;
        @(negedge clk); chk("t2_lsu_gnt", 64'(lsu_gnt_o), 1); chk("t2_if_gnt_lose", 64'(if_gnt_o), 0);
        cyc(); lsu_req_i = 0; mem_gnt_i = 1;
        @(negedge clk);
        chk("t2_mem_we", 64'(mem_we_o), 1);
        chk("t2_mem_be", 64'(mem_be_o), 64'h0F);
        chk("t2_mem_wdata", mem_wdata_o, 64'h1234);
        cyc(); mem_gnt_i = 0; mem_rvalid_i = 1;
        @(negedge clk); chk("t2_lsu_ack", 64'(lsu_rvalid_o), 1); chk("t2_if_b2b_gnt", 64'(if_gnt_o), 1);
        cyc(); mem_rvalid_i = 0; if_req_i = 0; mem_gnt_i = 1;
        @(negedge clk);
        chk("t2_no_idle_req", 64'(mem_req_o), 1);
        chk("t2_if_addr", mem_addr_o, 64'h300);
        chk("t2_if_be", 64'(mem_be_o), 64'hFF);
        cyc(); mem_gnt_i = 0; mem_rvalid_i = 1;
        cyc(); mem_rvalid_i = 0;
        cyc();

        // 3: starvation limit with a single-cycle memory
        grants = "";
        acc = 0;
        lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 64'h500; if_req_i = 1; if_addr_i = 64'h600;
        mem_gnt_i = 1;
        for (int i = 0; i < 40 && grants.len() < 6; i++) begin
            @(negedge clk);
            if (lsu_gnt_o) grants = {grants, "L"};
            if (if_gnt_o)  grants = {grants, "I"};
            acc = mem_req_o && mem_gnt_i;
            cyc();
            mem_rvalid_i = acc;
        end
        lsu_req_i = 0; if_req_i = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acc = mem_req_o && mem_gnt_i;
            cyc();
            mem_rvalid_i = acc;
        end
        mem_gnt_i = 0; mem_rvalid_i = 0;
        n_l_before_i = 0;
        for (int i = 0; i < grants.len() && grants[i] == "L"; i++) n_l_before_i++;
        chk("t3_grant_count", 64'(grants.len()), 6);
        chk("t3_lsu_wins_before_if", 64'(n_l_before_i), 4);
        chk("t3_sixth_grant_lsu", 64'(grants.len() == 6 && grants[5] == "L"), 1);
        cyc();

        // 4: stray response in IDLE
        mem_rvalid_i = 1; mem_rdata_i = 64'h55;
        @(negedge clk); chk("t4_if_rv", 64'(if_rvalid_o), 0); chk("t4_lsu_rv", 64'(lsu_rvalid_o), 0);
        cyc(); mem_rvalid_i = 0; mem_rdata_i = '0;
        @(negedge clk); chk("t4_err_set", 64'(protocol_err_o), 1);
        cyc(); cyc(); cyc();
        @(negedge clk); chk("t4_err_sticky", 64'(protocol_err_o), 1);
        cyc(); rst = 1;
        cyc(); rst = 0;
        @(negedge clk); chk("t4_err_cleared", 64'(protocol_err_o), 0);
        cyc();

        // 5: reset while waiting for a response, then a late response
        lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 64'h80;
        cyc(); lsu_req_i = 0; mem_gnt_i = 1;
        cyc(); mem_gnt_i = 0;
        rst = 1;
        #1;
        chk("t5_async_mem_req", 64'(mem_req_o), 0);
        chk("t5_async_addr_clr", mem_addr_o, 0);
        cyc(); rst = 0;
        cyc(); mem_rvalid_i = 1; mem_rdata_i = 64'hBEEF;
        @(negedge clk); chk("t5_late_dropped", 64'(lsu_rvalid_o), 0);
        cyc(); mem_rvalid_i = 0; mem_rdata_i = '0; if_req_i = 1; if_addr_i = 64'h200;
        @(negedge clk); chk("t5_err", 64'(protocol_err_o), 1); chk("t5_rearb_gnt", 64'(if_gnt_o), 1);
        cyc(); if_req_i = 0; mem_gnt_i = 1;
        cyc(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'h77;
        @(negedge clk); chk("t5_if_rv", 64'(if_rvalid_o), 1);
        cyc(); mem_rvalid_i = 0; mem_rdata_i = '0;
        cyc();

        // 6: store then load from LSU
        rv_start = n_lsu_rv;
        lsu_req_i = 1; lsu_we_i = 1; lsu_addr_i = 64'h10; lsu_wdata_i = 64'hAA; lsu_be_i = 8'hFF;
        cyc(); lsu_req_i = 0; mem_gnt_i = 1;
        cyc(); mem_gnt_i = 0; mem_rvalid_i = 1;
        @(negedge clk); chk("t6_store_ack", 64'(lsu_rvalid_o), 1);
        cyc(); mem_rvalid_i = 0; lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 64'h18;
        @(negedge clk); chk("t6_load_gnt", 64'(lsu_gnt_o), 1);
        cyc(); lsu_req_i = 0; mem_gnt_i = 1;
        cyc(); mem_gnt_i = 0;
        cyc(); mem_rvalid_i = 1; mem_rdata_i = 64'hCAFE;
        @(negedge clk); chk("t6_load_rv", 64'(lsu_rvalid_o), 1); chk("t6_load_data", lsu_rdata_o, 64'hCAFE);
        cyc(); mem_rvalid_i = 0; mem_rdata_i = '0;
        cyc(); cyc();
        chk("t6_lsu_rv_pulses", 64'(n_lsu_rv - rv_start), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
